multi_item_placer: RTL and testbench

- Parametrised item-placement engine for the snake game.
- Keeps a table of N_ITEMS item slots. On request, it places one slot at a random free grid cell that avoids every snake body segment and every other valid item.
- Sits between the game-control FSM (which issues requests and clears eaten items) and the renderer/collision logic (which read the flat item table).
- Uses an internal LFSR, rejection sampling for grids of any size up to 2^COORD_W, a sequential collision scan and a bounded retry count with failure reporting.

---
 rtl/multi_item_placer.sv | 155 +++++++++++++++
 tb/tb_multi_item_placer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_item_placer.sv
// Item-placement engine: places one item slot at a random free cell that avoids body segments and other valid items.
// Optional ITEM_SEED_LOAD_EN adds i_Seed_load/i_Seed to reload the LFSR.
module multi_item_placer #(
  parameter int          XSIZE     = 48,
  parameter int          YSIZE     = 64,
  parameter int          COORD_W   = 6,
  parameter int          MAX_SIZE  = 20,
  parameter int          N_ITEMS   = 4,
  parameter int          MAX_TRIES = 200,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         SLOT_W    = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
`ifdef ITEM_SEED_LOAD_EN
  input  logic                        i_Seed_load,
  input  logic [15:0]                 i_Seed,
`endif
  input  logic                        i_Req,
  input  logic [SLOT_W-1:0]           i_Slot,
  input  logic [N_ITEMS-1:0]          i_Clear,
  input  logic [MAX_SIZE*COORD_W-1:0] i_Body_x,
  input  logic [MAX_SIZE*COORD_W-1:0] i_Body_y,
  input  logic [11:0]                 i_Body_size,
  output logic                        o_Ready,
  output logic                        o_Done,
  output logic                        o_Fail,
  output logic [SLOT_W-1:0]           o_Done_slot,
  output logic [N_ITEMS*COORD_W-1:0]  o_Item_x,
  output logic [N_ITEMS*COORD_W-1:0]  o_Item_y,
  output logic [N_ITEMS-1:0]          o_Item_valid
);

  localparam int                 SCAN_LEN = MAX_SIZE + N_ITEMS;
  localparam int                 IDX_W    = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
  localparam logic [COORD_W:0]   X_LIM    = XSIZE[COORD_W:0];
  localparam logic [COORD_W:0]   Y_LIM    = YSIZE[COORD_W:0];
  localparam logic [7:0]         TRY_LIM  = MAX_TRIES[7:0];
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(SCAN_LEN - 1);

  typedef enum logic [2:0] {IDLE, DRAW, SCAN, DONE, FAIL} state_t;

  state_t             state, state_next;
  logic [15:0]        lfsr, lfsr_next;
  logic [COORD_W-1:0] draw_x, draw_y, cand_x, cand_y;
  logic               in_range, hit;
  logic [7:0]         tries, tries_inc;
  logic [IDX_W-1:0]   scan_idx;
  logic [SLOT_W-1:0]  slot;

  always_comb begin
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`ifdef ITEM_SEED_LOAD_EN
    // A zero seed would lock the LFSR, so it falls back to the reset seed.
    if (i_Seed_load) lfsr_next = (i_Seed == '0) ? LFSR_SEED : i_Seed;
`endif
  end

  always_comb begin
    draw_x    = lfsr[COORD_W-1:0];
    draw_y    = lfsr[2*COORD_W-1:COORD_W];
    in_range  = ({1'b0, draw_x} < X_LIM) && ({1'b0, draw_y} < Y_LIM);
    tries_inc = tries + 8'd1;
    o_Ready   = (state == IDLE);
  end

  // One table entry per scan cycle: body segments first, then the other item slots.
  always_comb begin
    hit = 1'b0;
    for (int unsigned k = 0; k < MAX_SIZE; k++) begin
      if (32'(scan_idx) == k && k < 32'(i_Body_size) &&
          i_Body_x[k*COORD_W +: COORD_W] == cand_x &&
          i_Body_y[k*COORD_W +: COORD_W] == cand_y)
        hit = 1'b1;
    end
    for (int unsigned j = 0; j < N_ITEMS; j++) begin
      if (32'(scan_idx) == MAX_SIZE + j && o_Item_valid[j] && 32'(slot) != j &&
          o_Item_x[j*COORD_W +: COORD_W] == cand_x &&
          o_Item_y[j*COORD_W +: COORD_W] == cand_y)
        hit = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (i_Req) state_next = DRAW;
      DRAW: begin
        if (in_range)                state_next = SCAN;
        else if (tries_inc == TRY_LIM) state_next = FAIL;
      end
      SCAN: begin
        if (hit)                       state_next = (tries == TRY_LIM) ? FAIL : DRAW;
        else if (scan_idx == IDX_LAST) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      FAIL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      lfsr         <= LFSR_SEED;
      tries        <= '0;
      scan_idx     <= '0;
      slot         <= '0;
      cand_x       <= '0;
      cand_y       <= '0;
      o_Done       <= 1'b0;
      o_Fail       <= 1'b0;
      o_Done_slot  <= '0;
      o_Item_x     <= '0;
      o_Item_y     <= '0;
      o_Item_valid <= '0;
    end else begin
      lfsr         <= lfsr_next;
      o_Done       <= (state == DONE);
      o_Fail       <= (state == FAIL);
      // The DONE write below overrides a clear of the same slot in the same cycle.
      o_Item_valid <= o_Item_valid & ~i_Clear;
      case (state)
        IDLE: begin
          if (i_Req) begin
            slot  <= i_Slot;
            tries <= '0;
          end
        end
        DRAW: begin
          tries <= tries_inc;
          if (in_range) begin
            cand_x   <= draw_x;
            cand_y   <= draw_y;
            scan_idx <= '0;
          end
        end
        SCAN: scan_idx <= scan_idx + 1'b1;
        DONE: begin
          o_Item_x[slot*COORD_W +: COORD_W] <= cand_x;
          o_Item_y[slot*COORD_W +: COORD_W] <= cand_y;
          o_Item_valid[slot]                <= 1'b1;
          o_Done_slot                       <= slot;
        end
        FAIL:    o_Done_slot <= slot;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_item_placer.sv
// Bench for multi_item_placer: a 2x2-grid instance for exact placement/latency cases and a default-size instance for rejection sampling.
module tb_multi_item_placer;

  logic clk, rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance: 2x2 grid, 4 segments, 2 slots, 10 tries
  logic        s_req, s_slot, s_ready, s_done, s_fail, s_done_slot;
  logic [1:0]  s_clear, s_item_x, s_item_y, s_valid;
  logic [3:0]  s_body_x, s_body_y;
  logic [11:0] s_size;
  // Default instance
  logic         d_req, d_ready, d_done, d_fail;
  logic [1:0]   d_slot, d_done_slot;
  logic [3:0]   d_clear, d_valid;
  logic [119:0] d_body_x, d_body_y;
  logic [11:0]  d_size;
  logic [23:0]  d_item_x, d_item_y;
`ifdef ITEM_SEED_LOAD_EN
  logic         s_seed_load, d_seed_load;
  logic [15:0]  s_seed, d_seed;
`endif

  multi_item_placer #(.XSIZE(2), .YSIZE(2), .COORD_W(1), .MAX_SIZE(4), .N_ITEMS(2), .MAX_TRIES(10)) dut_s (
    .i_Clk(clk), .i_Rst(rst),
`ifdef ITEM_SEED_LOAD_EN
    .i_Seed_load(s_seed_load), .i_Seed(s_seed),
`endif
    .i_Req(s_req), .i_Slot(s_slot), .i_Clear(s_clear),
    .i_Body_x(s_body_x), .i_Body_y(s_body_y), .i_Body_size(s_size),
    .o_Ready(s_ready), .o_Done(s_done), .o_Fail(s_fail), .o_Done_slot(s_done_slot),
    .o_Item_x(s_item_x), .o_Item_y(s_item_y), .o_Item_valid(s_valid));

  multi_item_placer dut_d (
    .i_Clk(clk), .i_Rst(rst),
`ifdef ITEM_SEED_LOAD_EN
    .i_Seed_load(d_seed_load), .i_Seed(d_seed),
`endif
    .i_Req(d_req), .i_Slot(d_slot), .i_Clear(d_clear),
    .i_Body_x(d_body_x), .i_Body_y(d_body_y), .i_Body_size(d_size),
    .o_Ready(d_ready), .o_Done(d_done), .o_Fail(d_fail), .o_Done_slot(d_done_slot),
    .o_Item_x(d_item_x), .o_Item_y(d_item_y), .o_Item_valid(d_valid));

  typedef struct {
    logic       fail;
    int         slot;
    int         lat;
    logic [1:0] valid, ix, iy;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0;
  logic [15:0] m_lfsr;
  logic        dv[4];
  logic [5:0]  dx[4], dy[4];

  function automatic logic [15:0] step_n(input logic [15:0] v, input int n);
    logic [15:0] r = v;
    for (int i = 0; i < n; i++) r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    return r;
  endfunction

  // Full 2x2 board: cell (x,y) is segment x+2y, so each attempt scans x+2y+1 entries before the hit.
  function automatic int full_lat(input logic [15:0] l);
    int cyc = 0;
    logic [15:0] v;
    for (int d = 0; d < 10; d++) begin
      cyc++;
      v = step_n(l, cyc);
      cyc += 1 + int'(v[0]) + 2 * int'(v[1]);
    end
    return cyc + 1;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= step_n(m_lfsr, 1);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for an LFSR phase where the first draw ({y,x}) is c1 and, optionally, the draw 7 cycles later is c2.
  task automatic wait_phase(input logic [1:0] c1, input logic use2, input logic [1:0] c2);
    logic [15:0] a, b;
    int   k = 0;
    logic ok = 1'b0;
    @(negedge clk);
    while (!ok && k < 4000) begin
      a  = step_n(m_lfsr, 1);
      b  = step_n(m_lfsr, 8);
      ok = (a[1:0] == c1) && (!use2 || b[1:0] == c2);
      if (!ok) begin
        @(negedge clk);
        k++;
      end
    end
    check("phase_search", ok, 1);
  endtask

  task automatic place_s(input logic slot, input exp_t e, input int clear_at);
    exp_t q;
    int   n = 0;
    logic got = 1'b0;
    sb.push_back(e);
    s_slot = slot;
    s_req  = 1'b1;
    @(posedge clk); #1 s_req = 1'b0;
    while (!got && n < 300) begin
      @(posedge clk); n++; #1;
      if (s_done || s_fail) got = 1'b1;
      s_clear = (n == clear_at) ? 2'b01 : 2'b00;
    end
    q = sb.pop_front();
    check("s_pulse_seen", got, 1);
    check("s_done", s_done, !q.fail);
    check("s_fail", s_fail, q.fail);
    check("s_latency", n, q.lat);
    check("s_done_slot", s_done_slot, q.slot);
    check("s_valid", s_valid, q.valid);
    check("s_item_x", s_item_x, q.ix);
    check("s_item_y", s_item_y, q.iy);
    @(posedge clk); #1;
    check("s_pulse_one_cycle", s_done | s_fail, 0);
  endtask

  task automatic place_d(input logic [1:0] slot, output logic [5:0] px, output logic [5:0] py);
    exp_t q;
    int   n = 0;
    logic got = 1'b0;
    sb.push_back('{fail: 1'b0, slot: int'(slot), lat: 26, valid: '0, ix: '0, iy: '0});
    @(negedge clk);
    d_slot = slot;
    d_req  = 1'b1;
    @(posedge clk); #1 d_req = 1'b0;
    while (!got && n < 6000) begin
      @(posedge clk); n++; #1;
      if (d_done || d_fail) got = 1'b1;
    end
    q  = sb.pop_front();
    px = d_item_x[q.slot*6 +: 6];
    py = d_item_y[q.slot*6 +: 6];
    check("d_pulse_seen", got, 1);
    check("d_done", d_done, !q.fail);
    check("d_fail", d_fail, q.fail);
    check("d_done_slot", d_done_slot, q.slot);
    check("d_latency_min", n >= q.lat, 1);
    check("d_x_range", px < 6'd48, 1);
    check("d_y_range", {26'd0, py} < 32'd64, 1);
    for (int j = 0; j < 4; j++)
      if (j != q.slot && dv[j]) check("d_distinct", {px, py} != {dx[j], dy[j]}, 1);
    dv[slot] = 1'b1;
    dx[slot] = px;
    dy[slot] = py;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] px, py;
    logic       seen;
    exp_t       e;
`ifdef ITEM_SEED_LOAD_EN
    logic [11:0] run1[4];
    s_seed_load = 1'b0; s_seed = '0; d_seed_load = 1'b0; d_seed = '0;
`endif
    rst = 1'b0;
    s_req = 1'b0; s_slot = 1'b0; s_clear = '0; s_body_x = '0; s_body_y = '0; s_size = '0;
    d_req = 1'b0; d_slot = '0; d_clear = '0; d_body_x = '0; d_body_y = '0; d_size = '0;
    for (int j = 0; j < 4; j++) begin dv[j] = 1'b0; dx[j] = '0; dy[j] = '0; end
    repeat (3) @(negedge clk);
    check("rst_ready", s_ready, 1);
    check("rst_done", s_done, 0);
    check("rst_fail", s_fail, 0);
    check("rst_done_slot", s_done_slot, 0);
    check("rst_valid", s_valid, 0);
    check("rst_item_xy", {s_item_x, s_item_y}, 0);
    check("rst_d_ready", d_ready, 1);
    check("rst_d_table", {d_valid, d_item_x, d_item_y}, 0);
    rst = 1'b1;

    // Single free cell (1,1); i_Clear of slot 0 during the DONE cycle loses to the write
    s_body_x = 4'b0010; s_body_y = 4'b0100; s_size = 12'd3;
    wait_phase(2'b11, 1'b0, 2'b00);
    e = '{fail: 1'b0, slot: 0, lat: 8, valid: 2'b01, ix: 2'b01, iy: 2'b01};
    place_s(1'b0, e, 7);

    // Reset in the middle of SCAN
    @(negedge clk);
    s_slot = 1'b0; s_req = 1'b1;
    @(posedge clk); #1 s_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_ready", s_ready, 1);
    check("midrst_valid", s_valid, 0);
    check("midrst_item_xy", {s_item_x, s_item_y}, 0);
    check("midrst_pulses", {s_done, s_fail}, 0);
    seen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) begin
      @(posedge clk); #1 seen |= s_done | s_fail;
    end
    check("midrst_no_pulse", seen, 0);

    // First request after reset, then clear in IDLE
    wait_phase(2'b11, 1'b0, 2'b00);
    e = '{fail: 1'b0, slot: 0, lat: 8, valid: 2'b01, ix: 2'b01, iy: 2'b01};
    place_s(1'b0, e, -1);
    @(negedge clk); s_clear = 2'b01;
    @(posedge clk); #1;
    check("clear_idle_valid", s_valid, 2'b00);
    s_clear = 2'b00;

    // Item avoidance: body (0,0),(1,0)
    s_body_x = 4'b0010; s_body_y = 4'b0000; s_size = 12'd2;
    wait_phase(2'b10, 1'b0, 2'b00);
    e = '{fail: 1'b0, slot: 0, lat: 8, valid: 2'b01, ix: 2'b00, iy: 2'b01};
    place_s(1'b0, e, -1);
    wait_phase(2'b11, 1'b0, 2'b00);
    e = '{fail: 1'b0, slot: 1, lat: 8, valid: 2'b11, ix: 2'b10, iy: 2'b11};
    place_s(1'b1, e, -1);
    // Re-place slot 0: first draw (1,1) hits slot 1, second draw (0,1) is its own old cell
    wait_phase(2'b11, 1'b1, 2'b10);
    e = '{fail: 1'b0, slot: 0, lat: 15, valid: 2'b11, ix: 2'b10, iy: 2'b11};
    place_s(1'b0, e, -1);

    // Board full: every attempt rejected, give up after 10 draws
    s_body_x = 4'b1010; s_body_y = 4'b1100; s_size = 12'd4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = '{fail: 1'b1, slot: 1 - i, lat: full_lat(m_lfsr), valid: 2'b11, ix: 2'b10, iy: 2'b11};
      place_s(1'(1 - i), e, -1);
    end

    // Rejection sampling on the default 48x64 grid, empty body
    for (int i = 0; i < 100; i++) place_d(2'(i % 4), px, py);

`ifdef ITEM_SEED_LOAD_EN
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      d_clear = 4'hF; d_seed = 16'h1234; d_seed_load = 1'b1;
      for (int j = 0; j < 4; j++) dv[j] = 1'b0;
      @(negedge clk);
      d_clear = '0; d_seed_load = 1'b0;
      for (int i = 0; i < 4; i++) begin
        place_d(2'(i), px, py);
        if (r == 0) run1[i] = {px, py};
        else        check("seed_repeat", {px, py}, run1[i]);
      end
    end
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
